// File: rtl/tx_py_pkg.sv
// Shared definitions for the tx payload sequencer and the Bluetooth CRC-16 LFSR.
package tx_py_pkg;

    localparam int unsigned PYBITCNT_W    = 13;
    localparam logic [15:0] BT_CRC16_POLY = 16'h1021;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_CRC  = 2'd2;
    localparam logic [1:0] ST_END  = 2'd3;

    typedef logic [1:0] py_state_t;

    function automatic logic [15:0] crc_seed(input logic [7:0] uap);
        return {8'h00, uap};
    endfunction

endpackage

// File: rtl/bt_crc16_lfsr.sv
// Serial Bluetooth CRC-16 (x^16 + x^12 + x^5 + 1) register with seed load and shift enable.
module bt_crc16_lfsr (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        shift_en,
    input  logic        din,
    output logic [15:0] crc
);
    import tx_py_pkg::*;

    logic        fb;
    logic [15:0] crc_d;

    always_comb begin
        fb    = din ^ crc[15];
        crc_d = {crc[14:0], 1'b0} ^ (fb ? BT_CRC16_POLY : 16'h0000);
    end

    // Load has priority so a new payload always starts from a clean seed
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            crc <= 16'h0000;
        end else if (load) begin
            crc <= seed;
        end else if (shift_en) begin
            crc <= crc_d;
        end
    end

endmodule

// File: rtl/tx_pyseq.sv
// Transmit payload sequencer: walks the tx buffer bit by bit, appends the
// Bluetooth CRC-16 and flags payload end for the ACL ping-pong buffer select.
module tx_pyseq #(
    parameter int unsigned PYBITCNT_W = tx_py_pkg::PYBITCNT_W,
    parameter int unsigned LEN_W      = 11
) (
    input  logic                  clk_6M,
    input  logic                  rstz,
    input  logic                  txbit_p,
    input  logic                  py_start_p,
    input  logic [LEN_W-1:0]      py_len_bytes,
    input  logic                  crc_en,
    input  logic [7:0]            uap,
    input  logic                  abort_p,
    input  logic                  lnctrl_txpybitin,
    output logic [PYBITCNT_W-1:0] pybitcount,
    output logic                  py_datperiod,
    output logic                  crc_period,
    output logic                  py_endp,
    output logic                  txpybit_out,
    output logic                  busy
);
    import tx_py_pkg::*;

    localparam int unsigned CMP_W = PYBITCNT_W + 1;

    py_state_t             state_q, state_d;
    logic [LEN_W-1:0]      len_q;
    logic                  crc_en_q;
    logic [3:0]            cnt_q;
    logic [PYBITCNT_W-1:0] pybitcount_q;
    logic                  txbit_q;
    logic [15:0]           crc;

    logic [CMP_W-1:0]      bits_total;
    logic [CMP_W-1:0]      last_idx;
    logic                  at_last;
    logic                  start_ok;
    logic                  data_tick;
    logic                  crc_tick;

    // Bit count is compared at one bit wider than the counter so len*8-1 never wraps
    assign bits_total = CMP_W'({len_q, 3'b000});
    assign last_idx   = bits_total - CMP_W'(1);
    assign at_last    = ({1'b0, pybitcount_q} == last_idx);

    assign start_ok  = (state_q == ST_IDLE) && py_start_p && !abort_p;
    assign data_tick = (state_q == ST_DATA) && txbit_p && !abort_p;
    assign crc_tick  = (state_q == ST_CRC) && txbit_p && !abort_p;

    always_comb begin
        state_d = state_q;
        if (abort_p) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (py_start_p) begin
                        state_d = (py_len_bytes == '0) ? ST_END : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (txbit_p && at_last) begin
                        state_d = crc_en_q ? ST_CRC : ST_END;
                    end
                end
                ST_CRC: begin
                    if (txbit_p && (cnt_q == 4'd0)) begin
                        state_d = ST_END;
                    end
                end
                ST_END:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            crc_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                len_q    <= py_len_bytes;
                crc_en_q <= crc_en;
            end
        end
    end

    // Counter holds on the last data bit and keeps its value through CRC, END and IDLE
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            pybitcount_q <= '0;
        end else if (start_ok) begin
            pybitcount_q <= '0;
        end else if (data_tick && !at_last) begin
            pybitcount_q <= pybitcount_q + PYBITCNT_W'(1);
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            cnt_q <= 4'd0;
        end else if (data_tick && at_last && crc_en_q) begin
            cnt_q <= 4'd15;
        end else if (crc_tick) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            txbit_q <= 1'b0;
        end else if (abort_p) begin
            txbit_q <= 1'b0;
        end else if (data_tick) begin
            txbit_q <= lnctrl_txpybitin;
        end else if (crc_tick) begin
            txbit_q <= crc[cnt_q];
        end
    end

    bt_crc16_lfsr u_crc (
        .clk_6M   (clk_6M),
        .rstz     (rstz),
        .load     (start_ok),
        .seed     (crc_seed(uap)),
        .shift_en (data_tick),
        .din      (lnctrl_txpybitin),
        .crc      (crc)
    );

    assign pybitcount   = pybitcount_q;
    assign txpybit_out  = txbit_q;
    assign py_datperiod = (state_q == ST_DATA);
    assign crc_period   = (state_q == ST_CRC);
    assign py_endp      = (state_q == ST_END) && !abort_p;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_pyseq.sv
// Self-checking bench for tx_pyseq: random buffer contents and tick spacing
// checked against a bit-stream model built from the payload bytes.
module tb_tx_pyseq;

    localparam int PW = 13;
    localparam int LW = 11;

    logic          clk_6M = 1'b0;
    logic          rstz;
    logic          txbit_p;
    logic          py_start_p;
    logic [LW-1:0] py_len_bytes;
    logic          crc_en;
    logic [7:0]    uap;
    logic          abort_p;
    logic          lnctrl_txpybitin;
    logic [PW-1:0] pybitcount;
    logic          py_datperiod;
    logic          crc_period;
    logic          py_endp;
    logic          txpybit_out;
    logic          busy;

    logic [8191:0] bufbits;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            exp_q[$];
    bit            obs_q[$];
    int            dat_ticks;

    always #5 clk_6M = ~clk_6M;

    // Buffer model: flat bit array, word [12:5] / bit [4:0] is just bit index pybitcount
    assign lnctrl_txpybitin = bufbits[pybitcount];

    tx_pyseq u_dut (
        .clk_6M           (clk_6M),
        .rstz             (rstz),
        .txbit_p          (txbit_p),
        .py_start_p       (py_start_p),
        .py_len_bytes     (py_len_bytes),
        .crc_en           (crc_en),
        .uap              (uap),
        .abort_p          (abort_p),
        .lnctrl_txpybitin (lnctrl_txpybitin),
        .pybitcount       (pybitcount),
        .py_datperiod     (py_datperiod),
        .crc_period       (crc_period),
        .py_endp          (py_endp),
        .txpybit_out      (txpybit_out),
        .busy             (busy)
    );

    task automatic step();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic fill_buffer();
        for (int i = 0; i < 256; i++) bufbits[i*32 +: 32] = $urandom();
    endtask

    function automatic logic [15:0] model_crc(input logic [7:0] u, input int nbits);
        logic [15:0] c;
        bit          f;
        c = {8'h00, u};
        for (int i = 0; i < nbits; i++) begin
            f = bufbits[i] ^ c[15];
            c = (c << 1) ^ (f ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic void build_expected(input int len, input bit ce, input logic [7:0] u);
        logic [15:0] c;
        exp_q.delete();
        if (len == 0) return;
        for (int i = 0; i < len * 8; i++) exp_q.push_back(bufbits[i]);
        if (ce) begin
            c = model_crc(u, len * 8);
            for (int b = 15; b >= 0; b--) exp_q.push_back(c[b]);
        end
    endfunction

    function automatic logic [15:0] observed_crc(input int first);
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 0; i < 16; i++) v = {v[14:0], obs_q[first+i]};
        return v;
    endfunction

    task automatic run_payload(input int len, input bit ce, input logic [7:0] u,
                               input int start_at, input bit start_with_tick,
                               input int abort_at, input bit abort_with_tick);
        int   total;
        int   ndata;
        int   exp_cnt;
        int   endp_seen;
        int   hold_err;
        logic pre_dat;
        build_expected(len, ce, u);
        total     = exp_q.size();
        ndata     = len * 8;
        obs_q.delete();
        dat_ticks = 0;
        endp_seen = 0;
        hold_err  = 0;
        py_len_bytes = LW'(len);
        crc_en       = ce;
        uap          = u;
        py_start_p   = 1'b1;
        txbit_p      = start_with_tick;
        step();
        py_start_p   = 1'b0;
        txbit_p      = 1'b0;
        py_len_bytes = LW'($urandom_range(1, 9));
        crc_en       = 1'($urandom());
        uap          = 8'($urandom());
        if (len == 0) begin
            n_checks++;
            if (py_endp !== 1'b1) begin
                n_fail++; $display("FAIL len0_endp: got %b want 1", py_endp);
            end
            n_checks++;
            if (py_datperiod !== 1'b0 || crc_period !== 1'b0) begin
                n_fail++; $display("FAIL len0_periods: got dat=%b crc=%b want 0 0",
                                   py_datperiod, crc_period);
            end
            step();
            n_checks++;
            if (py_endp !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL len0_after: got endp=%b busy=%b want 0 0", py_endp, busy);
            end
            return;
        end
        n_checks++;
        if (busy !== 1'b1 || pybitcount !== '0) begin
            n_fail++; $display("FAIL start_state: got busy=%b cnt=%0d want 1 0", busy, pybitcount);
        end
        for (int k = 0; k < total; k++) begin
            repeat ($urandom_range(0, 4)) begin
                step();
                if (py_endp === 1'b1) endp_seen++;
                if (k > 0 && txpybit_out !== exp_q[k-1]) hold_err++;
            end
            if (k == start_at) begin
                py_start_p = 1'b1;
                step();
                py_start_p = 1'b0;
            end
            exp_cnt = (k < ndata) ? k : ndata - 1;
            n_checks++;
            if (pybitcount !== PW'(exp_cnt)) begin
                n_fail++; $display("FAIL bitcount[%0d]: got %0d want %0d", k, pybitcount, exp_cnt);
            end
            n_checks++;
            if (py_datperiod !== (k < ndata) || crc_period !== (k >= ndata)) begin
                n_fail++; $display("FAIL periods[%0d]: got dat=%b crc=%b want %b %b", k,
                                   py_datperiod, crc_period, k < ndata, k >= ndata);
            end
            if (k == abort_at) begin
                abort_p = 1'b1;
                txbit_p = abort_with_tick;
                step();
                abort_p = 1'b0;
                txbit_p = 1'b0;
                n_checks++;
                if (busy !== 1'b0 || py_endp !== 1'b0 || txpybit_out !== 1'b0) begin
                    n_fail++; $display("FAIL abort_state: got busy=%b endp=%b bit=%b want 0 0 0",
                                       busy, py_endp, txpybit_out);
                end
                n_checks++;
                if (py_datperiod !== 1'b0 || crc_period !== 1'b0) begin
                    n_fail++; $display("FAIL abort_periods: got dat=%b crc=%b want 0 0",
                                       py_datperiod, crc_period);
                end
                n_checks++;
                if (pybitcount !== PW'(exp_cnt)) begin
                    n_fail++; $display("FAIL abort_count: got %0d want %0d", pybitcount, exp_cnt);
                end
                repeat (4) begin
                    step();
                    if (py_endp === 1'b1 || busy === 1'b1) endp_seen++;
                end
                n_checks++;
                if (endp_seen != 0) begin
                    n_fail++; $display("FAIL abort_quiet: got %0d endp/busy cycles want 0", endp_seen);
                end
                return;
            end
            pre_dat = py_datperiod;
            txbit_p = 1'b1;
            step();
            txbit_p = 1'b0;
            if (pre_dat === 1'b1) dat_ticks++;
            obs_q.push_back(txpybit_out);
            n_checks++;
            if (txpybit_out !== exp_q[k]) begin
                n_fail++; $display("FAIL txbit[%0d]: got %b want %b", k, txpybit_out, exp_q[k]);
            end
            n_checks++;
            if (py_endp !== (k == total - 1)) begin
                n_fail++; $display("FAIL endp[%0d]: got %b want %b", k, py_endp, k == total - 1);
            end
        end
        step();
        n_checks++;
        if (py_endp !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_state: got endp=%b busy=%b want 0 0", py_endp, busy);
        end
        n_checks++;
        if (pybitcount !== PW'(ndata - 1) || txpybit_out !== exp_q[total-1]) begin
            n_fail++; $display("FAIL done_hold: got cnt=%0d bit=%b want %0d %b", pybitcount,
                               txpybit_out, ndata - 1, exp_q[total-1]);
        end
        n_checks++;
        if (endp_seen != 0 || hold_err != 0) begin
            n_fail++; $display("FAIL gaps: got endp=%0d hold_err=%0d want 0 0", endp_seen, hold_err);
        end
        n_checks++;
        if (dat_ticks != ndata) begin
            n_fail++; $display("FAIL dat_ticks: got %0d want %0d", dat_ticks, ndata);
        end
    endtask

    task automatic test_reset();
        rstz = 1'b0;
        repeat (2) @(posedge clk_6M);
        #1;
        n_checks++;
        if (pybitcount !== '0 || py_datperiod !== 1'b0 || crc_period !== 1'b0 ||
            py_endp !== 1'b0 || txpybit_out !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got cnt=%0d dat=%b crc=%b endp=%b bit=%b busy=%b want all 0",
                               pybitcount, py_datperiod, crc_period, py_endp, txpybit_out, busy);
        end
        @(negedge clk_6M);
        rstz = 1'b1;
        step();
    endtask

    task automatic test_basic_a5();
        bufbits[31:0] = 32'h000000A5;
        run_payload(1, 1'b0, 8'h3C, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_crc_9188();
        bufbits[31:0] = 32'h00000001;
        run_payload(1, 1'b1, 8'h00, -1, 1'b0, -1, 1'b0);
        n_checks++;
        if (obs_q.size() != 24) begin
            n_fail++; $display("FAIL crc9188_len: got %0d bits want 24", obs_q.size());
        end else if (observed_crc(8) !== 16'h9188) begin
            n_fail++; $display("FAIL crc9188_value: got %h want 9188", observed_crc(8));
        end
    endtask

    task automatic test_crc_zero();
        bufbits[31:0] = 32'h00000000;
        run_payload(1, 1'b1, 8'h00, -1, 1'b0, -1, 1'b0);
        n_checks++;
        if (obs_q.size() != 24) begin
            n_fail++; $display("FAIL crczero_len: got %0d bits want 24", obs_q.size());
        end else if (observed_crc(8) !== 16'h0000) begin
            n_fail++; $display("FAIL crczero_value: got %h want 0000", observed_crc(8));
        end
    endtask

    task automatic test_word_boundary();
        fill_buffer();
        run_payload(5, 1'b0, 8'h00, -1, 1'b0, -1, 1'b0);
        n_checks++;
        if (pybitcount[12:5] !== 8'd1) begin
            n_fail++; $display("FAIL word_addr: got %0d want 1", pybitcount[12:5]);
        end
    endtask

    task automatic test_abort();
        fill_buffer();
        run_payload(4, 1'b1, 8'h5A, -1, 1'b0, 10, 1'b1);
        run_payload(1, 1'b0, 8'h00, -1, 1'b0, -1, 1'b0);
        run_payload(1, 1'b1, 8'h77, -1, 1'b0, 12, 1'b0);
    endtask

    task automatic test_len0();
        run_payload(0, 1'b1, 8'hFF, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_start_busy();
        fill_buffer();
        run_payload(3, 1'b1, 8'h21, 5, 1'b0, -1, 1'b0);
        run_payload(2, 1'b1, 8'h9E, 20, 1'b0, -1, 1'b0);
    endtask

    task automatic test_start_with_tick();
        fill_buffer();
        run_payload(2, 1'b0, 8'h00, -1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_tick_idle();
        fill_buffer();
        run_payload(2, 1'b0, 8'h00, -1, 1'b0, -1, 1'b0);
        repeat (3) begin
            txbit_p = 1'b1;
            step();
            txbit_p = 1'b0;
            step();
        end
        n_checks++;
        if (pybitcount !== PW'(15) || txpybit_out !== bufbits[15] || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_tick: got cnt=%0d bit=%b busy=%b want 15 %b 0",
                               pybitcount, txpybit_out, busy, bufbits[15]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            fill_buffer();
            run_payload($urandom_range(1, 24), 1'($urandom()), 8'($urandom()), -1, 1'b0, -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int endp_seen;
        fill_buffer();
        py_len_bytes = LW'(3);
        crc_en       = 1'b1;
        py_start_p   = 1'b1;
        step();
        py_start_p   = 1'b0;
        repeat (5) begin
            txbit_p = 1'b1;
            step();
            txbit_p = 1'b0;
        end
        #2;
        rstz = 1'b0;
        #1;
        n_checks++;
        if (pybitcount !== '0 || busy !== 1'b0 || txpybit_out !== 1'b0 ||
            py_datperiod !== 1'b0 || py_endp !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got cnt=%0d busy=%b bit=%b dat=%b endp=%b want all 0",
                               pybitcount, busy, txpybit_out, py_datperiod, py_endp);
        end
        @(negedge clk_6M);
        rstz = 1'b1;
        endp_seen = 0;
        repeat (4) begin
            step();
            if (py_endp === 1'b1 || busy === 1'b1) endp_seen++;
        end
        n_checks++;
        if (endp_seen != 0) begin
            n_fail++; $display("FAIL reset_quiet: got %0d endp/busy cycles want 0", endp_seen);
        end
    endtask

    initial begin
        rstz         = 1'b0;
        txbit_p      = 1'b0;
        py_start_p   = 1'b0;
        py_len_bytes = '0;
        crc_en       = 1'b0;
        uap          = 8'h00;
        abort_p      = 1'b0;
        fill_buffer();
        test_reset();
        test_basic_a5();
        test_crc_9188();
        test_crc_zero();
        test_word_boundary();
        test_abort();
        test_len0();
        test_start_busy();
        test_start_with_tick();
        test_tick_idle();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
